// File: rtl/button_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// button_fifo_ctrl
//
// Purpose: button-driven FIFO occupancy controller for the FPGA board build.
// It takes two raw active-low push buttons (write, read) and turns each one
// into a synchronised, debounced, single-cycle press pulse. From these pulses
// it tracks the write/read pointers, occupancy, full/empty, sticky
// overflow/underflow and a 7-segment occupancy readout for a FIFO of DEPTH
// entries. The accept strobes and pointers drive a downstream RAM.
//
// Optional feature macro: AUTO_REPEAT_EN
//   defined   : a held button re-fires after REPEAT_DELAY cycles and then
//               every REPEAT_PERIOD cycles
//   undefined : one pulse per press, no repeat logic
//
// Ports (button_fifo_ctrl):
//   internal_clk_fgpa  in   1        sole clock, rising edge
//   reset              in   1        asynchronous, active-high
//   nwrite_en          in   1        raw write button, active-low
//   nread_en           in   1        raw read button, active-low
//   wr_accept          out  1        write accepted this cycle
//   rd_accept          out  1        read accepted this cycle
//   wr_ptr             out  PTR_W    next write slot
//   rd_ptr             out  PTR_W    next read slot
//   count              out  PTR_W+1  occupancy 0..DEPTH
//   full / empty       out  1        count==DEPTH / count==0
//   overflow/underflow out  1        sticky reject flags, cleared by reset
//   fifo_stage         out  2        00 empty, 01 low, 10 high half, 11 full
//   fifo_state_segs    out  8        [7]=dp, [6:0]=g..a, active-low
//
// Ports (button_pulse):
//   i_clk, i_rst       clock, async active-high reset
//   i_btn_n            raw active-low button
//   o_pulse            registered one-cycle press (or repeat) pulse
// ---------------------------------------------------------------------------

module button_pulse #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_deb;
   logic             r_deb_d;
   logic [CNT_W-1:0] r_cnt;
   logic             w_rise;

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
      $error("DEBOUNCE_CYCLES must be at least 2");
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= ~i_btn_n;
         r_sync2 <= r_sync1;
      end
   end

   // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing
   // samples; any agreeing sample throws the progress away.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_deb   <= 1'b0;
         r_deb_d <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_deb_d <= r_deb;
         if (r_sync2 == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign w_rise = r_deb & ~r_deb_d;

`ifdef AUTO_REPEAT_EN
   // Down-counter armed on the press pulse; a zero count while still held
   // fires a repeat and reloads with the (shorter) period.
   logic [31:0] r_rpt;
   logic        w_rpt_hit;

   assign w_rpt_hit = r_deb & r_deb_d & (r_rpt == 32'd0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rpt <= '0;
      end else if (!r_deb) begin
         r_rpt <= '0;
      end else if (w_rise) begin
         r_rpt <= 32'(REPEAT_DELAY - 1);
      end else if (w_rpt_hit) begin
         r_rpt <= 32'(REPEAT_PERIOD - 1);
      end else begin
         r_rpt <= r_rpt - 32'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_pulse <= 1'b0;
      else       o_pulse <= w_rise | w_rpt_hit;
   end
`else
   // Repeat timing is unused in this build; still reject nonsense values.
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rpt
      $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_pulse <= 1'b0;
      else       o_pulse <= w_rise;
   end
`endif

endmodule

module button_fifo_ctrl #(
   parameter int  DEPTH           = 8,
   parameter int  DEBOUNCE_CYCLES = 250000,
   parameter int  REPEAT_DELAY    = 50000000,
   parameter int  REPEAT_PERIOD   = 10000000,
   localparam int PTR_W           = $clog2(DEPTH)
) (
   input  logic             internal_clk_fgpa,
   input  logic             reset,
   input  logic             nwrite_en,
   input  logic             nread_en,
   output logic             wr_accept,
   output logic             rd_accept,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow,
   output logic [1:0]       fifo_stage,
   output logic [7:0]       fifo_state_segs
);

   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two in 2..256");
   end

   logic             w_wr_pulse;
   logic             w_rd_pulse;
   logic             w_full_i;
   logic             w_empty_i;
   logic             w_wr_ok;
   logic             w_rd_ok;
   logic [PTR_W:0]   r_cnt;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             r_ovf;
   logic             r_udf;
   logic [8:0]       w_cnt_x;
   logic [6:0]       w_hex;
   logic [7:0]       w_segs;
   logic [1:0]       w_stage;

   button_pulse #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_wr_btn (
      .i_clk   (internal_clk_fgpa),
      .i_rst   (reset),
      .i_btn_n (nwrite_en),
      .o_pulse (w_wr_pulse)
   );

   button_pulse #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_rd_btn (
      .i_clk   (internal_clk_fgpa),
      .i_rst   (reset),
      .i_btn_n (nread_en),
      .o_pulse (w_rd_pulse)
   );

   // Decisions use internal state that updates on the accept edge, so a
   // pulse in the very next cycle sees the effect of the previous accept.
   assign w_full_i  = (r_cnt == (PTR_W+1)'(DEPTH));
   assign w_empty_i = (r_cnt == '0);
   // A write into a full FIFO is fine when a read drains a slot this cycle.
   assign w_wr_ok   = w_wr_pulse & (~w_full_i | w_rd_pulse);
   assign w_rd_ok   = w_rd_pulse & ~w_empty_i;

   always_ff @(posedge internal_clk_fgpa or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ovf     <= 1'b0;
         r_udf     <= 1'b0;
         wr_accept <= 1'b0;
         rd_accept <= 1'b0;
      end else begin
         wr_accept <= w_wr_ok;
         rd_accept <= w_rd_ok;
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
         if (w_wr_pulse && w_full_i && !w_rd_pulse) r_ovf <= 1'b1;
         if (w_rd_pulse && w_empty_i)               r_udf <= 1'b1;
      end
   end

   assign w_cnt_x = 9'(r_cnt);

   always_comb begin
      w_hex = 7'h7F;
      case (w_cnt_x[3:0])
         4'h0: w_hex = 7'h40;
         4'h1: w_hex = 7'h79;
         4'h2: w_hex = 7'h24;
         4'h3: w_hex = 7'h30;
         4'h4: w_hex = 7'h19;
         4'h5: w_hex = 7'h12;
         4'h6: w_hex = 7'h02;
         4'h7: w_hex = 7'h78;
         4'h8: w_hex = 7'h00;
         4'h9: w_hex = 7'h10;
         4'hA: w_hex = 7'h08;
         4'hB: w_hex = 7'h03;
         4'hC: w_hex = 7'h46;
         4'hD: w_hex = 7'h21;
         4'hE: w_hex = 7'h06;
         4'hF: w_hex = 7'h0E;
         default: w_hex = 7'h7F;
      endcase
   end

   // Beyond one hex digit, show "F" with the decimal point lit.
   always_comb begin
      w_segs = {1'b1, w_hex};
      if (w_cnt_x > 9'd15) w_segs = {1'b0, 7'h0E};
   end

   always_comb begin
      w_stage = 2'b01;
      if (w_empty_i)                                   w_stage = 2'b00;
      else if (w_full_i)                               w_stage = 2'b11;
      else if (r_cnt >= (PTR_W+1)'(DEPTH / 2))         w_stage = 2'b10;
   end

   // Status outputs trail the accept strobe by one cycle.
   always_ff @(posedge internal_clk_fgpa or posedge reset) begin
      if (reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         full            <= 1'b0;
         empty           <= 1'b1;
         overflow        <= 1'b0;
         underflow       <= 1'b0;
         fifo_stage      <= 2'b00;
         fifo_state_segs <= 8'hC0;
      end else begin
         wr_ptr          <= r_wr_ptr;
         rd_ptr          <= r_rd_ptr;
         count           <= r_cnt;
         full            <= w_full_i;
         empty           <= w_empty_i;
         overflow        <= r_ovf;
         underflow       <= r_udf;
         fifo_stage      <= w_stage;
         fifo_state_segs <= w_segs;
      end
   end

endmodule

// File: tb/tb_button_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_fifo_ctrl
//
// Directed bench: one DEPTH=8 and one DEPTH=32 controller, both with a
// debounce of 4 cycles, driven by scripted button presses. Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------

module tb_button_fifo_ctrl;

   logic clk_sys = 1'b0;
   logic rst     = 1'b1;
   logic nwr8    = 1'b1;
   logic nrd8    = 1'b1;
   logic nwr32   = 1'b1;
   logic nrd32   = 1'b1;

   logic       wr_acc8, rd_acc8;
   logic [2:0] wr_ptr8, rd_ptr8;
   logic [3:0] cnt8;
   logic       full8, empty8, ovf8, udf8;
   logic [1:0] stage8;
   logic [7:0] segs8;

   logic       wr_acc32, rd_acc32;
   logic [4:0] wr_ptr32, rd_ptr32;
   logic [5:0] cnt32;
   logic       full32, empty32, ovf32, udf32;
   logic [1:0] stage32;
   logic [7:0] segs32;

   int n_checks = 0;
   int n_errors = 0;

   int wr_hi8 = 0, wr_rise8 = 0, rd_hi8 = 0;
   int wr_hi32 = 0;
   logic wr_prev8 = 1'b0;

   always #5 clk_sys = ~clk_sys;

   button_fifo_ctrl #(.DEPTH(8), .DEBOUNCE_CYCLES(4)) u_dut8 (
      .internal_clk_fgpa (clk_sys),
      .reset             (rst),
      .nwrite_en         (nwr8),
      .nread_en          (nrd8),
      .wr_accept         (wr_acc8),
      .rd_accept         (rd_acc8),
      .wr_ptr            (wr_ptr8),
      .rd_ptr            (rd_ptr8),
      .count             (cnt8),
      .full              (full8),
      .empty             (empty8),
      .overflow          (ovf8),
      .underflow         (udf8),
      .fifo_stage        (stage8),
      .fifo_state_segs   (segs8)
   );

   button_fifo_ctrl #(.DEPTH(32), .DEBOUNCE_CYCLES(4)) u_dut32 (
      .internal_clk_fgpa (clk_sys),
      .reset             (rst),
      .nwrite_en         (nwr32),
      .nread_en          (nrd32),
      .wr_accept         (wr_acc32),
      .rd_accept         (rd_acc32),
      .wr_ptr            (wr_ptr32),
      .rd_ptr            (rd_ptr32),
      .count             (cnt32),
      .full              (full32),
      .empty             (empty32),
      .overflow          (ovf32),
      .underflow         (udf32),
      .fifo_stage        (stage32),
      .fifo_state_segs   (segs32)
   );

   always @(negedge clk_sys) begin
      if (wr_acc8) wr_hi8++;
      if (wr_acc8 && !wr_prev8) wr_rise8++;
      wr_prev8 = wr_acc8;
      if (rd_acc8) rd_hi8++;
      if (wr_acc32) wr_hi32++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(2);
   endtask

   // sel bit0 = write8, bit1 = read8, bit2 = write32
   task automatic press(input logic [2:0] sel);
      @(negedge clk_sys);
      if (sel[0]) nwr8  = 1'b0;
      if (sel[1]) nrd8  = 1'b0;
      if (sel[2]) nwr32 = 1'b0;
      cycles(8);
      nwr8 = 1'b1; nrd8 = 1'b1; nwr32 = 1'b1;
      cycles(10);
   endtask

   // Drive write8 low/high for n cycles.
   task automatic wr8_level(input logic lvl, input int n);
      nwr8 = lvl;
      cycles(n);
   endtask

   task automatic check_reset8(input string pfx);
      check_eq({pfx, "_cnt"},   32'(cnt8),    32'd0);
      check_eq({pfx, "_empty"}, 32'(empty8),  32'd1);
      check_eq({pfx, "_full"},  32'(full8),   32'd0);
      check_eq({pfx, "_stage"}, 32'(stage8),  32'd0);
      check_eq({pfx, "_segs"},  32'(segs8),   32'hC0);
      check_eq({pfx, "_wacc"},  32'(wr_acc8), 32'd0);
      check_eq({pfx, "_racc"},  32'(rd_acc8), 32'd0);
      check_eq({pfx, "_ptrs"},  32'({wr_ptr8, rd_ptr8}), 32'd0);
      check_eq({pfx, "_flags"}, 32'({ovf8, udf8}), 32'd0);
   endtask

   initial begin
      int base_wr, base_rd;

      // Reset values while reset is asserted
      cycles(3);
      check_reset8("rst");
      check_eq("rst32_segs", 32'(segs32), 32'hC0);
      rst = 1'b0;
      cycles(2);

      // First write with exact latency: stable from edge k, strobe in k+7
      @(negedge clk_sys);
      nwr8 = 1'b0;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk_sys);
         if (j == 7) check_eq("lat_wacc_early", 32'(wr_acc8), 32'd0);
         if (j == 8) begin
            check_eq("lat_wacc_on", 32'(wr_acc8), 32'd1);
            check_eq("lat_cnt_old", 32'(cnt8),    32'd0);
         end
         if (j == 9) begin
            check_eq("lat_wacc_off", 32'(wr_acc8), 32'd0);
            check_eq("lat_cnt_new",  32'(cnt8),    32'd1);
         end
      end
      nwr8 = 1'b1;
      cycles(10);

      // Two more clean writes
      press(3'b001);
      press(3'b001);
      check_eq("w3_pulses", 32'(wr_hi8),   32'd3);
      check_eq("w3_width",  32'(wr_rise8), 32'd3);
      check_eq("w3_cnt",    32'(cnt8),     32'd3);
      check_eq("w3_wptr",   32'(wr_ptr8),  32'd3);
      check_eq("w3_stage",  32'(stage8),   32'b01);
      check_eq("w3_segs",   32'(segs8),    32'hB0);

      // Bouncy press: 2-cycle glitches then a settled press -> one accept
      @(negedge clk_sys);
      wr8_level(1'b0, 2); wr8_level(1'b1, 2);
      wr8_level(1'b0, 2); wr8_level(1'b1, 2);
      wr8_level(1'b0, 8); wr8_level(1'b1, 10);
      check_eq("bounce_pulses", 32'(wr_hi8), 32'd4);
      check_eq("bounce_cnt",    32'(cnt8),   32'd4);
      check_eq("bounce_segs",   32'(segs8),  32'h99);

      // 3-cycle glitch only -> nothing
      wr8_level(1'b0, 3); wr8_level(1'b1, 10);
      check_eq("glitch_pulses", 32'(wr_hi8), 32'd4);
      check_eq("glitch_cnt",    32'(cnt8),   32'd4);

      // Nine writes from empty
      do_reset();
      check_reset8("rst2");
      for (int i = 0; i < 9; i++) press(3'b001);
      check_eq("fill_cnt",   32'(cnt8),    32'd8);
      check_eq("fill_full",  32'(full8),   32'd1);
      check_eq("fill_stage", 32'(stage8),  32'b11);
      check_eq("fill_ovf",   32'(ovf8),    32'd1);
      check_eq("fill_wptr",  32'(wr_ptr8), 32'd0);
      check_eq("fill_segs",  32'(segs8),   32'h80);
      base_rd = rd_hi8;
      press(3'b010);
      check_eq("rd_pulse", 32'(rd_hi8 - base_rd), 32'd1);
      check_eq("rd_cnt",   32'(cnt8),    32'd7);
      check_eq("rd_rptr",  32'(rd_ptr8), 32'd1);
      check_eq("rd_ovf",   32'(ovf8),    32'd1);
      check_eq("rd_full",  32'(full8),   32'd0);
      check_eq("rd_stage", 32'(stage8),  32'b10);
      check_eq("rd_segs",  32'(segs8),   32'hF8);

      // Simultaneous read and write on empty
      do_reset();
      base_wr = wr_hi8;
      base_rd = rd_hi8;
      press(3'b011);
      check_eq("both0_wacc", 32'(wr_hi8 - base_wr), 32'd1);
      check_eq("both0_racc", 32'(rd_hi8 - base_rd), 32'd0);
      check_eq("both0_udf",  32'(udf8),  32'd1);
      check_eq("both0_cnt",  32'(cnt8),  32'd1);
      check_eq("both0_segs", 32'(segs8), 32'hF9);
      for (int i = 0; i < 4; i++) press(3'b001);
      check_eq("five_cnt", 32'(cnt8), 32'd5);
      press(3'b011);
      check_eq("both5_cnt",  32'(cnt8),    32'd5);
      check_eq("both5_wptr", 32'(wr_ptr8), 32'd6);
      check_eq("both5_rptr", 32'(rd_ptr8), 32'd1);
      check_eq("both5_segs", 32'(segs8),   32'h92);
      check_eq("both5_udf",  32'(udf8),    32'd1);

      // DEPTH=32: 20 writes -> "F." readout
      do_reset();
      for (int i = 0; i < 20; i++) press(3'b100);
      check_eq("d32_cnt",   32'(cnt32),   32'd20);
      check_eq("d32_segs",  32'(segs32),  32'h0E);
      check_eq("d32_stage", 32'(stage32), 32'b10);
      check_eq("d32_wptr",  32'(wr_ptr32), 32'd20);

      // Reset mid-press, button still held when reset releases
      base_wr = wr_hi32;
      @(negedge clk_sys);
      nwr32 = 1'b0;
      cycles(3);
      rst = 1'b1;
      #1;
      check_eq("midrst_cnt",   32'(cnt32),   32'd0);
      check_eq("midrst_segs",  32'(segs32),  32'hC0);
      check_eq("midrst_empty", 32'(empty32), 32'd1);
      check_eq("midrst_wptr",  32'(wr_ptr32), 32'd0);
      cycles(1);
      check_eq("midrst_stage", 32'(stage32), 32'd0);
      check_eq("midrst_wacc",  32'(wr_acc32), 32'd0);
      cycles(1);
      rst = 1'b0;
      cycles(12);
      nwr32 = 1'b1;
      cycles(10);
      check_eq("requal_pulses", 32'(wr_hi32 - base_wr), 32'd1);
      check_eq("requal_cnt",    32'(cnt32), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
